// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend: collects keypad digits into ATM request fields and
// presents LOGIN / OPERATION requests on a valid/ready handshake.
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        req_ready,
    output logic        req_valid,
    output logic        req_kind,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic [2:0]  menu_option,
    output logic [10:0] amount,
    output logic [11:0] dest_acc,
    output logic        exit,
    output logic        entry_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_ACC, S_PIN, S_LOGIN, S_MENU, S_DEST, S_AMT, S_OP
    } state_t;

    state_t        r_state, w_state;
    logic [13:0]   r_buf, w_buf;
    logic [2:0]    r_cnt, w_cnt;
    logic [TW-1:0] r_timer, w_timer;
    logic [11:0]   r_acc, w_acc;
    logic [3:0]    r_pin, w_pin;
    logic [2:0]    r_menu, w_menu;
    logic [10:0]   r_amt, w_amt;
    logic [11:0]   r_dest, w_dest;
    logic          r_exit, w_exit;
    logic          r_err, w_err;

    logic          w_req;
    logic          w_key;
    logic          w_digit;
    logic          w_timeout;
    logic [2:0]    w_limit;
    logic [13:0]   w_sum;
    logic          w_le4095;

    assign w_req     = (r_state == S_LOGIN) || (r_state == S_OP);
    assign w_key     = key_valid && !w_req && (key_code <= 4'd12);
    assign w_digit   = w_key && (key_code < 4'd10);
    assign w_timeout = !w_req && (r_timer == TW'(TIMEOUT_CYCLES));
    assign w_limit   = (r_state == S_PIN || r_state == S_MENU) ? 3'd1 : 3'd4;
    assign w_sum     = r_buf * 14'd10 + {10'd0, key_code};
    assign w_le4095  = (r_buf <= 14'd4095);

    assign req_valid   = w_req;
    assign req_kind    = (r_state == S_OP);
    assign acc_number  = r_acc;
    assign pin         = r_pin;
    assign menu_option = r_menu;
    assign amount      = r_amt;
    assign dest_acc    = r_dest;
    assign exit        = r_exit;
    assign entry_error = r_err;

    // Next-state, field latching, pulse and inactivity-timer logic
    always_comb begin
        w_state = r_state;
        w_buf   = r_buf;
        w_cnt   = r_cnt;
        w_acc   = r_acc;
        w_pin   = r_pin;
        w_menu  = r_menu;
        w_amt   = r_amt;
        w_dest  = r_dest;
        w_exit  = 1'b0;
        w_err   = 1'b0;

        if (w_req) begin
            w_timer = r_timer;
        end else if (w_key || (r_state == S_ACC && r_cnt == 3'd0)) begin
            w_timer = '0;
        end else begin
            w_timer = r_timer + TW'(1);
        end

        if (w_timeout || (w_key && key_code == 4'd12)) begin
            w_state = S_ACC;
            w_buf   = '0;
            w_cnt   = '0;
            w_acc   = '0;
            w_pin   = '0;
            w_menu  = '0;
            w_amt   = '0;
            w_dest  = '0;
            w_timer = '0;
            w_exit  = 1'b1;
        end else if (w_req) begin
            if (req_ready) begin
                w_state = S_MENU;
            end
        end else if (w_digit) begin
            if (r_cnt < w_limit) begin
                w_buf = w_sum;
                w_cnt = r_cnt + 3'd1;
            end else begin
                w_err = 1'b1;
            end
        end else if (w_key && key_code == 4'd11) begin
            w_buf = '0;
            w_cnt = '0;
        end else if (w_key && key_code == 4'd10) begin
            w_buf = '0;
            w_cnt = '0;
            case (r_state)
                S_ACC: begin
                    if (r_cnt != 3'd0 && w_le4095) begin
                        w_acc   = r_buf[11:0];
                        w_state = S_PIN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_PIN: begin
                    if (r_cnt == 3'd1) begin
                        w_pin   = r_buf[3:0];
                        w_state = S_LOGIN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_MENU: begin
                    if (r_cnt == 3'd1 && r_buf >= 14'd3 && r_buf <= 14'd7) begin
                        w_menu = r_buf[2:0];
                        if (r_buf == 14'd3) begin
                            w_amt   = '0;
                            w_state = S_OP;
                        end else if (r_buf == 14'd6) begin
                            w_state = S_DEST;
                        end else begin
                            w_state = S_AMT;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_DEST: begin
                    if (r_cnt != 3'd0 && w_le4095) begin
                        w_dest  = r_buf[11:0];
                        w_state = S_AMT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_AMT: begin
                    if (r_cnt != 3'd0 && r_buf <= 14'd2047) begin
                        w_amt   = r_buf[10:0];
                        w_state = S_OP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: begin
                    w_state = r_state;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ACC;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_acc   <= '0;
            r_pin   <= '0;
            r_menu  <= '0;
            r_amt   <= '0;
            r_dest  <= '0;
            r_exit  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_buf   <= w_buf;
            r_cnt   <= w_cnt;
            r_timer <= w_timer;
            r_acc   <= w_acc;
            r_pin   <= w_pin;
            r_menu  <= w_menu;
            r_amt   <= w_amt;
            r_dest  <= w_dest;
            r_exit  <= w_exit;
            r_err   <= w_err;
        end
    end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb_atm_keypad_frontend: directed test-plan sequence followed by random
// key traffic, all outputs compared every cycle against a reference model.
module tb_atm_keypad_frontend;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        req_ready = 1'b0;
    logic        req_valid;
    logic        req_kind;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [10:0] amount;
    logic [11:0] dest_acc;
    logic        exit;
    logic        entry_error;

    int n_assert = 0;
    int n_fail = 0;

    atm_keypad_frontend #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .req_ready(req_ready),
        .req_valid(req_valid),
        .req_kind(req_kind),
        .acc_number(acc_number),
        .pin(pin),
        .menu_option(menu_option),
        .amount(amount),
        .dest_acc(dest_acc),
        .exit(exit),
        .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    // Reference model: phase name, queue of entered digits, idle counter
    typedef enum {ACC, PIN, LOGIN, MENU, DEST, AMT, OP} ph_t;
    ph_t ph = ACC;
    int dq[$];
    int idle = 0;
    int m_acc = 0, m_pin = 0, m_menu = 0, m_amt = 0, m_dest = 0;
    bit m_exit = 0, m_err = 0;

    function automatic int dval();
        int v = 0;
        foreach (dq[i]) v = v * 10 + dq[i];
        return v;
    endfunction

    task automatic clear_all();
        dq.delete();
        m_acc = 0; m_pin = 0; m_menu = 0; m_amt = 0; m_dest = 0;
        ph = ACC;
        idle = 0;
    endtask

    task automatic model_edge(bit rst, bit kv, int kc, bit rdy);
        bit req, akey, tout;
        int v, n, lim;
        m_exit = 0;
        m_err = 0;
        if (rst) begin
            clear_all();
            return;
        end
        req  = (ph == LOGIN || ph == OP);
        akey = kv && !req && kc <= 12;
        tout = !req && idle == TO;
        if (!req) begin
            if (akey || (ph == ACC && dq.size() == 0)) idle = 0;
            else idle++;
        end
        if (tout || (akey && kc == 12)) begin
            clear_all();
            m_exit = 1;
        end else if (req) begin
            if (rdy) ph = MENU;
        end else if (akey && kc < 10) begin
            lim = (ph == PIN || ph == MENU) ? 1 : 4;
            if (dq.size() < lim) dq.push_back(kc);
            else m_err = 1;
        end else if (akey && kc == 11) begin
            dq.delete();
        end else if (akey && kc == 10) begin
            v = dval();
            n = dq.size();
            dq.delete();
            case (ph)
                ACC:  if (n >= 1 && v <= 4095) begin m_acc = v; ph = PIN; end
                      else m_err = 1;
                PIN:  if (n == 1) begin m_pin = v; ph = LOGIN; end
                      else m_err = 1;
                MENU: if (n == 1 && v >= 3 && v <= 7) begin
                          m_menu = v;
                          if (v == 3) begin m_amt = 0; ph = OP; end
                          else if (v == 6) ph = DEST;
                          else ph = AMT;
                      end else m_err = 1;
                DEST: if (n >= 1 && v <= 4095) begin m_dest = v; ph = AMT; end
                      else m_err = 1;
                AMT:  if (n >= 1 && v <= 2047) begin m_amt = v; ph = OP; end
                      else m_err = 1;
                default: ;
            endcase
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_req_valid", req_valid, (ph == LOGIN || ph == OP));
        chk("m_req_kind", req_kind, (ph == OP));
        chk("m_acc", acc_number, m_acc);
        chk("m_pin", pin, m_pin);
        chk("m_menu", menu_option, m_menu);
        chk("m_amount", amount, m_amt);
        chk("m_dest", dest_acc, m_dest);
        chk("m_exit", exit, m_exit);
        chk("m_err", entry_error, m_err);
    endtask

    task automatic step(bit rst, bit kv, logic [3:0] kc, bit rdy);
        reset = rst;
        key_valid = kv;
        key_code = kc;
        req_ready = rdy;
        @(posedge clk);
        model_edge(rst, kv, int'(kc), rdy);
        #1;
        check_all();
        reset = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        req_ready = 1'b0;
    endtask

    task automatic key(logic [3:0] k);
        step(1'b0, 1'b1, k, 1'b0);
    endtask

    task automatic idle_step(bit rdy);
        step(1'b0, 1'b0, 4'd0, rdy);
    endtask

    task automatic login();
        key(2); key(1); key(7); key(5); key(10); key(1); key(10);
    endtask

    initial begin
        int found, nexit, r;
        bit kv, rdy;
        logic [3:0] kc;

        // Reset state
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_req_valid", req_valid, 0);
        chk("reset_acc", acc_number, 0);
        idle_step(1'b1);
        chk("ready_idle_no_effect", req_valid, 0);

        // Login with held request
        login();
        chk("login_valid", req_valid, 1);
        chk("login_kind", req_kind, 0);
        chk("login_acc", acc_number, 2175);
        chk("login_pin", pin, 1);
        for (int i = 0; i < 5; i++) begin
            idle_step(1'b0);
            chk("login_hold_valid", req_valid, 1);
            chk("login_hold_acc", acc_number, 2175);
        end
        idle_step(1'b1);
        chk("login_drop", req_valid, 0);

        // Transaction
        key(6); key(10); key(2); key(4); key(2); key(9); key(10);
        key(3); key(0); key(0); key(10);
        chk("txn_valid", req_valid, 1);
        chk("txn_kind", req_kind, 1);
        chk("txn_menu", menu_option, 6);
        chk("txn_dest", dest_acc, 2429);
        chk("txn_amount", amount, 300);
        idle_step(1'b1);
        chk("txn_drop", req_valid, 0);

        // Amount out of range, then a valid amount
        key(4); key(10);
        key(2); key(0); key(4); key(8); key(10);
        chk("amt_range_err", entry_error, 1);
        idle_step(1'b0);
        chk("amt_err_pulse_end", entry_error, 0);
        key(5); key(10);
        chk("amt_retry_valid", req_valid, 1);
        chk("amt_retry_value", amount, 5);
        idle_step(1'b1);

        // Bad menu option, then cancel in amount entry
        key(2); key(10);
        chk("menu_err", entry_error, 1);
        key(7); key(10);
        key(12);
        chk("cancel_exit", exit, 1);
        chk("cancel_acc", acc_number, 0);
        chk("cancel_menu", menu_option, 0);
        idle_step(1'b0);
        chk("cancel_exit_end", exit, 0);

        // Fifth account digit rejected
        key(1); key(2); key(3); key(4); key(5);
        chk("acc_fifth_err", entry_error, 1);
        key(10);
        chk("acc_fifth_value", acc_number, 1234);
        key(12);

        // CLEAR inside account entry
        key(9); key(9); key(11); key(4); key(10);
        chk("clear_acc", acc_number, 4);
        key(12);

        // Inactivity timeout after login handshake
        login();
        idle_step(1'b1);
        found = -1;
        for (int k = 1; k <= 40; k++) begin
            idle_step(1'b0);
            if (exit === 1'b1 && found < 0) found = k;
        end
        chk("timeout_cycle", found, 21);

        // No timeout while idle with an empty account buffer
        nexit = 0;
        for (int k = 0; k < 100; k++) begin
            idle_step(1'b0);
            if (exit !== 1'b0) nexit++;
        end
        chk("idle_acc_no_exit", nexit, 0);

        // Reset during a pending request
        login();
        chk("pre_reset_valid", req_valid, 1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_req_drop", req_valid, 0);
        chk("reset_acc_clear", acc_number, 0);
        chk("reset_pin_clear", pin, 0);

        // Random key traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 9) kc = 4'(r);
            else if (r <= 13) kc = 4'd10;
            else if (r == 14) kc = 4'd11;
            else if (r == 15) kc = 4'd12;
            else kc = 4'(13 + (r - 16) % 3);
            kv = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, kv, kc, rdy);
            end else if ($urandom_range(0, 99) == 0) begin
                for (int j = 0; j < 25; j++) idle_step(1'b0);
            end else begin
                step(1'b0, kv, kc, rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Keypad front-end for the ATM core. It collects decimal key presses into the account number, PIN, menu option, destination account and amount fields. It presents each completed entry to the ATM core as a held request on a valid/ready handshake. It also generates the exit pulse on cancel or inactivity timeout, so it is the transmitting end of the ATM core's user-input interface.

## Interface
- TIMEOUT_CYCLES, 1000: idle cycles without a key press before the session is forcibly ended.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is sampled when high.
- key_code  in  4  key: 0–9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL; 13–15 ignored.
- req_ready  in  1  ATM core accepts the current request.
- req_valid  out  1  request pending; all req_* and field outputs are stable while high.
- req_kind  out  1  0 = LOGIN (acc_number, pin), 1 = OPERATION (menu_option, amount, dest_acc).
- acc_number  out  12  binary account number.
- pin  out  4  PIN, 0–9.
- menu_option  out  3  operation code: 3 BALANCE, 4 WITHDRAW, 5 WITHDRAW_SHOW_BALANCE, 6 TRANSACTION, 7 DEPOSIT.
- amount  out  11  binary amount, 0–2047.
- dest_acc  out  12  destination account for TRANSACTION.
- exit  out  1  one-cycle pulse that ends the session.
- entry_error  out  1  one-cycle pulse when a key is rejected.

## Operation
- States:
  - S_ACC, S_PIN, S_LOGIN (request), S_MENU, S_DEST, S_AMT, S_OP (request).
- Digit accumulation:
  - On each accepted digit, the buffer becomes buffer*10 + digit, computed 14 bits wide.
  - A digit counter tracks entries. Field digit limits: acc/dest 4, amount 4, pin 1, menu 1.
  - A digit beyond the field limit is discarded and pulses entry_error.
- CLEAR empties the buffer and digit counter and stays in the current state.
- ENTER validates the buffer against the current field. If valid, the buffer is latched into the field output, cleared, and the state advances. If invalid, entry_error pulses, the buffer is cleared, and the state is unchanged.
  - S_ACC: at least 1 digit and value ≤ 4095 → acc_number, then S_PIN.
  - S_PIN: exactly 1 digit → pin, then S_LOGIN (req_kind 0).
  - S_MENU: exactly 1 digit with value 3..7 → menu_option.
    - 3 → S_OP.
    - 4, 5, 7 → S_AMT.
    - 6 → S_DEST.
  - S_DEST: at least 1 digit and value ≤ 4095 → dest_acc, then S_AMT.
  - S_AMT: at least 1 digit and value ≤ 2047 → amount, then S_OP (req_kind 1).
- BALANCE (option 3) drives amount = 0.
- S_LOGIN and S_OP: req_valid = 1. On the edge with req_ready = 1, go to S_MENU. Keys arriving in these states are ignored, including CANCEL.
- CANCEL in any non-request state: exit pulses, all fields and the buffer clear to 0, state becomes S_ACC.
- Timeout counter:
  - Cleared on every accepted key.
  - Frozen in S_LOGIN/S_OP.
  - Held at 0 in S_ACC while the digit counter is 0.
  - Otherwise increments each cycle. On reaching TIMEOUT_CYCLES it behaves exactly as CANCEL.
- Reset: state S_ACC; every output 0 (req_valid, exit, entry_error, all fields); buffer, digit counter and timer 0. Reset mid-request drops req_valid on the next cycle with no handshake.

## Timing
- A key is accepted on the rising edge where key_valid = 1. Its effect (state, field, pulses) is visible the following cycle.
- ENTER that completes a request raises req_valid 1 cycle after the key edge.
- The transfer occurs on the edge with req_valid & req_ready; req_valid is low the next cycle. Back-to-back requests are impossible: a new request needs at least two further key presses.
- req_ready while req_valid = 0 has no effect.
- exit and entry_error last exactly one cycle, registered 1 cycle after the cause.
- Timeout fires on the cycle the counter equals TIMEOUT_CYCLES; exit is high the next cycle.
- Simultaneous reset with any event: reset wins.

## Test plan
- Login: keys 2,1,7,5,ENTER,1,ENTER → req_valid=1, req_kind=0, acc_number=2175, pin=1. Hold req_ready=0 for 5 cycles → all outputs stable. Raise req_ready → req_valid low the next cycle; state S_MENU.
- Transaction: after login, keys 6,ENTER,2,4,2,9,ENTER,3,0,0,ENTER → req_kind=1, menu_option=6, dest_acc=2429, amount=300.
- Range errors:
  - Amount 2,0,4,8,ENTER → entry_error pulse; state stays S_AMT; buffer 0.
  - Fifth acc digit → entry_error pulse; value unchanged.
  - Menu 2,ENTER → entry_error pulse.
- CLEAR/CANCEL:
  - Keys 9,9,CLEAR,4,ENTER in S_ACC → acc_number=4.
  - CANCEL in S_AMT → exit pulse 1 cycle; all fields 0; state S_ACC.
- Timeout (TIMEOUT_CYCLES=20): login then idle → exit pulse exactly 21 cycles after the accepted req_ready edge. Idle in S_ACC with empty buffer for 100 cycles → no exit.
- Reset while req_valid=1 → next cycle req_valid=0, state S_ACC, all outputs 0.
